// File: rtl/plab2_proc_imul_arbiter.sv
// Round-robin arbiter sharing one variable-latency integer multiplier among
// p_nreqs requesters. One operation in flight at a time; the response is
// routed back to the requester that issued it.
module plab2_proc_imul_arbiter #(
  parameter int unsigned p_nreqs      = 4,
  parameter int unsigned p_msg_nbits  = 67,
  parameter int unsigned p_resp_nbits = 32,
  localparam int unsigned c_ptr_nbits = (p_nreqs > 1) ? $clog2(p_nreqs) : 1
) (
  input  logic                             clk,
  input  logic                             reset,

  input  logic [p_nreqs-1:0]               req_val,
  output logic [p_nreqs-1:0]               req_rdy,
  input  logic [p_nreqs*p_msg_nbits-1:0]   req_msg,

  output logic [p_nreqs-1:0]               resp_val,
  input  logic [p_nreqs-1:0]               resp_rdy,
  output logic [p_resp_nbits-1:0]          resp_msg,

  output logic                             mul_in_val,
  input  logic                             mul_in_rdy,
  output logic [p_msg_nbits-1:0]           mul_in_msg,

  input  logic                             mul_out_val,
  output logic                             mul_out_rdy,
  input  logic [p_resp_nbits-1:0]          mul_out_msg,

  output logic                             busy,
  output logic [c_ptr_nbits-1:0]           owner
);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  localparam logic [c_ptr_nbits:0] c_nreqs_ext = (c_ptr_nbits+1)'(p_nreqs);

  state_t                  r_state;
  state_t                  w_state_next;
  logic [c_ptr_nbits-1:0]  r_prio_ptr;
  logic [c_ptr_nbits-1:0]  r_owner;

  logic                    w_any_val;
  logic [c_ptr_nbits-1:0]  w_grant;
  logic [c_ptr_nbits-1:0]  w_grant_inc;
  logic [p_msg_nbits-1:0]  w_sel_msg;
  logic                    w_issue_fire;

  assign w_any_val = |req_val;

  // Round-robin search starting at the priority pointer, wrapping mod p_nreqs
  always_comb begin
    logic                   v_found;
    logic [c_ptr_nbits:0]   v_sum;
    logic [c_ptr_nbits:0]   v_inc;
    v_found = 1'b0;
    v_sum   = '0;
    w_grant = '0;
    for (int unsigned k = 0; k < p_nreqs; k++) begin
      v_sum = {1'b0, r_prio_ptr} + k[c_ptr_nbits:0];
      if (v_sum >= c_nreqs_ext) begin
        v_sum = v_sum - c_nreqs_ext;
      end
      if (!v_found && req_val[v_sum[c_ptr_nbits-1:0]]) begin
        v_found = 1'b1;
        w_grant = v_sum[c_ptr_nbits-1:0];
      end
    end
    v_inc = {1'b0, w_grant} + 1'b1;
    if (v_inc >= c_nreqs_ext) begin
      v_inc = '0;
    end
    w_grant_inc = v_inc[c_ptr_nbits-1:0];
  end

  // Select the granted requester's message slice
  always_comb begin
    w_sel_msg = '0;
    for (int unsigned i = 0; i < p_nreqs; i++) begin
      if (w_grant == i[c_ptr_nbits-1:0]) begin
        w_sel_msg = req_msg[i*p_msg_nbits +: p_msg_nbits];
      end
    end
  end

  // Next-state and handshake outputs; everything is held quiet while in reset
  always_comb begin
    w_state_next = r_state;
    w_issue_fire = 1'b0;
    req_rdy      = '0;
    resp_val     = '0;
    mul_in_val   = 1'b0;
    mul_in_msg   = '0;
    mul_out_rdy  = 1'b0;
    busy         = 1'b0;
    if (!reset) begin
      unique case (r_state)
        IDLE: begin
          mul_in_val = w_any_val;
          if (w_any_val) begin
            mul_in_msg = w_sel_msg;
          end
          for (int unsigned i = 0; i < p_nreqs; i++) begin
            if (w_any_val && (w_grant == i[c_ptr_nbits-1:0])) begin
              req_rdy[i] = mul_in_rdy;
            end
          end
          if (w_any_val && mul_in_rdy) begin
            w_issue_fire = 1'b1;
            w_state_next = BUSY;
          end
        end
        BUSY: begin
          busy = 1'b1;
          for (int unsigned i = 0; i < p_nreqs; i++) begin
            if (r_owner == i[c_ptr_nbits-1:0]) begin
              resp_val[i] = mul_out_val;
              mul_out_rdy = resp_rdy[i];
            end
          end
          if (mul_out_val && mul_out_rdy) begin
            w_state_next = IDLE;
          end
        end
        default: w_state_next = IDLE;
      endcase
    end
  end

  assign resp_msg = mul_out_msg;
  assign owner    = reset ? '0 : r_owner;

  // State, priority pointer and owner registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_prio_ptr <= '0;
      r_owner    <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_issue_fire) begin
        r_owner    <= w_grant;
        r_prio_ptr <= w_grant_inc;
      end
    end
  end

endmodule

// File: tb/tb_plab2_proc_imul_arbiter.sv
// Directed bench for the multiplier arbiter: a 4-requester instance and a
// 3-requester instance, each fed by a behavioural variable-latency multiplier.
module tb_plab2_proc_imul_arbiter;

  localparam int MW = 67;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests  = 0;
  int failed = 0;

  // ---------------- instance A: 4 requesters ----------------
  logic            a_reset = 1'b1;
  logic [3:0]      a_req_val = '0;
  logic [3:0]      a_req_rdy;
  logic [4*MW-1:0] a_req_msg = '0;
  logic [3:0]      a_resp_val;
  logic [3:0]      a_resp_rdy = '1;
  logic [31:0]     a_resp_msg;
  logic            a_mul_in_val, a_mul_in_rdy;
  logic [MW-1:0]   a_mul_in_msg;
  logic            a_mul_out_val, a_mul_out_rdy;
  logic [31:0]     a_mul_out_msg;
  logic            a_busy;
  logic [1:0]      a_owner;
  logic            a_force_outval = 1'b0;

  plab2_proc_imul_arbiter #(.p_nreqs(4), .p_msg_nbits(MW), .p_resp_nbits(32)) dut_a (
    .clk(clk), .reset(a_reset),
    .req_val(a_req_val), .req_rdy(a_req_rdy), .req_msg(a_req_msg),
    .resp_val(a_resp_val), .resp_rdy(a_resp_rdy), .resp_msg(a_resp_msg),
    .mul_in_val(a_mul_in_val), .mul_in_rdy(a_mul_in_rdy), .mul_in_msg(a_mul_in_msg),
    .mul_out_val(a_mul_out_val), .mul_out_rdy(a_mul_out_rdy), .mul_out_msg(a_mul_out_msg),
    .busy(a_busy), .owner(a_owner)
  );

  logic        a_m_busy = 1'b0;
  int          a_m_cnt  = 0;
  int          a_lat    = 1;
  logic [31:0] a_m_res  = '0;

  assign a_mul_in_rdy  = !a_m_busy;
  assign a_mul_out_val = (a_m_busy && a_m_cnt == 0) || a_force_outval;
  assign a_mul_out_msg = a_m_res;

  always @(posedge clk) begin
    if (a_reset) begin
      a_m_busy <= 1'b0;
      a_m_cnt  <= 0;
    end else if (!a_m_busy) begin
      if (a_mul_in_val) begin
        a_m_busy <= 1'b1;
        a_m_cnt  <= a_lat - 1;
        a_m_res  <= a_mul_in_msg[63:32] * a_mul_in_msg[31:0];
      end
    end else if (a_m_cnt != 0) begin
      a_m_cnt <= a_m_cnt - 1;
    end else if (a_mul_out_rdy) begin
      a_m_busy <= 1'b0;
    end
  end

  // ---------------- instance B: 3 requesters ----------------
  logic            b_reset = 1'b1;
  logic [2:0]      b_req_val = '0;
  logic [2:0]      b_req_rdy;
  logic [3*MW-1:0] b_req_msg = '0;
  logic [2:0]      b_resp_val;
  logic [2:0]      b_resp_rdy = '1;
  logic [31:0]     b_resp_msg;
  logic            b_mul_in_val, b_mul_in_rdy;
  logic [MW-1:0]   b_mul_in_msg;
  logic            b_mul_out_val, b_mul_out_rdy;
  logic [31:0]     b_mul_out_msg;
  logic            b_busy;
  logic [1:0]      b_owner;

  plab2_proc_imul_arbiter #(.p_nreqs(3), .p_msg_nbits(MW), .p_resp_nbits(32)) dut_b (
    .clk(clk), .reset(b_reset),
    .req_val(b_req_val), .req_rdy(b_req_rdy), .req_msg(b_req_msg),
    .resp_val(b_resp_val), .resp_rdy(b_resp_rdy), .resp_msg(b_resp_msg),
    .mul_in_val(b_mul_in_val), .mul_in_rdy(b_mul_in_rdy), .mul_in_msg(b_mul_in_msg),
    .mul_out_val(b_mul_out_val), .mul_out_rdy(b_mul_out_rdy), .mul_out_msg(b_mul_out_msg),
    .busy(b_busy), .owner(b_owner)
  );

  logic        b_m_busy = 1'b0;
  int          b_m_cnt  = 0;
  int          b_lat    = 1;
  logic [31:0] b_m_res  = '0;

  assign b_mul_in_rdy  = !b_m_busy;
  assign b_mul_out_val = b_m_busy && b_m_cnt == 0;
  assign b_mul_out_msg = b_m_res;

  always @(posedge clk) begin
    if (b_reset) begin
      b_m_busy <= 1'b0;
      b_m_cnt  <= 0;
    end else if (!b_m_busy) begin
      if (b_mul_in_val) begin
        b_m_busy <= 1'b1;
        b_m_cnt  <= b_lat - 1;
        b_m_res  <= b_mul_in_msg[63:32] * b_mul_in_msg[31:0];
      end
    end else if (b_m_cnt != 0) begin
      b_m_cnt <= b_m_cnt - 1;
    end else if (b_mul_out_rdy) begin
      b_m_busy <= 1'b0;
    end
  end

  // ---------------- helpers (stimulus / waiting only) ----------------
  function automatic logic [MW-1:0] mk(input logic [2:0] f, input logic [31:0] a,
                                       input logic [31:0] b);
    return {f, a, b};
  endfunction

  task automatic a_do_reset();
    @(negedge clk);
    a_reset = 1'b1; a_req_val = '0; a_resp_rdy = '1; a_force_outval = 1'b0;
    @(negedge clk);
    a_reset = 1'b0;
  endtask

  task automatic b_do_reset();
    @(negedge clk);
    b_reset = 1'b1; b_req_val = '0; b_resp_rdy = '1;
    @(negedge clk);
    b_reset = 1'b0;
  endtask

  // Wait (bounded) for a nonzero req_rdy; g = granted index, -1 on timeout
  task automatic a_wait_issue(output int g);
    g = -1;
    for (int c = 0; c < 40; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (a_req_rdy != 0) begin
        for (int i = 0; i < 4; i++) if (a_req_rdy[i]) g = i;
        break;
      end
    end
  endtask

  task automatic a_wait_resp(output logic [3:0] rv);
    rv = '0;
    for (int c = 0; c < 40; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (a_resp_val != 0) begin
        rv = a_resp_val;
        break;
      end
    end
  endtask

  task automatic b_wait_issue(output int g);
    g = -1;
    for (int c = 0; c < 40; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (b_req_rdy != 0) begin
        for (int i = 0; i < 3; i++) if (b_req_rdy[i]) g = i;
        break;
      end
    end
  endtask

  task automatic b_wait_resp(output logic [2:0] rv);
    rv = '0;
    for (int c = 0; c < 40; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (b_resp_val != 0) begin
        rv = b_resp_val;
        break;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    a_reset = 1'b1; a_req_val = 4'b1111;
    @(negedge clk); @(negedge clk); #1;
    tests++;
    if ({a_req_rdy, a_resp_val, a_mul_in_val, a_mul_out_rdy, a_busy, a_owner} !== '0) begin
      failed++;
      $display("FAIL reset.during req_rdy=%b resp_val=%b in_val=%b out_rdy=%b busy=%b owner=%0d exp all 0",
               a_req_rdy, a_resp_val, a_mul_in_val, a_mul_out_rdy, a_busy, a_owner);
    end
    a_req_val = '0; a_reset = 1'b0;
    @(negedge clk); #1;
    tests++;
    if ({a_req_rdy, a_resp_val, a_mul_in_val, a_mul_out_rdy, a_busy, a_owner} !== '0) begin
      failed++;
      $display("FAIL reset.after req_rdy=%b resp_val=%b in_val=%b out_rdy=%b busy=%b owner=%0d exp all 0",
               a_req_rdy, a_resp_val, a_mul_in_val, a_mul_out_rdy, a_busy, a_owner);
    end
  endtask

  task automatic test_single();
    int g; logic [3:0] rv; logic [MW-1:0] m;
    a_do_reset();
    a_lat = 3;
    m = mk(3'd0, 32'd7, 32'd6);
    a_req_msg[2*MW +: MW] = m;
    a_req_val = 4'b0100;
    a_wait_issue(g);
    tests++;
    if (g !== 2) begin failed++; $display("FAIL single.grant got=%0d exp=2", g); end
    tests++;
    if (a_req_rdy !== 4'b0100) begin failed++; $display("FAIL single.req_rdy got=%b exp=0100", a_req_rdy); end
    tests++;
    if (a_mul_in_msg !== m || a_mul_in_val !== 1'b1) begin
      failed++; $display("FAIL single.in_msg got=%h val=%b exp=%h val=1", a_mul_in_msg, a_mul_in_val, m);
    end
    @(negedge clk); a_req_val = '0; #1;
    tests++;
    if (a_busy !== 1'b1 || a_owner !== 2'd2) begin
      failed++; $display("FAIL single.busy got busy=%b owner=%0d exp busy=1 owner=2", a_busy, a_owner);
    end
    a_wait_resp(rv);
    tests++;
    if (rv !== 4'b0100 || a_resp_msg !== 32'd42) begin
      failed++; $display("FAIL single.resp got val=%b msg=%0d exp val=0100 msg=42", rv, a_resp_msg);
    end
    @(negedge clk); #1;
    tests++;
    if (a_busy !== 1'b0 || a_resp_val !== 4'b0000) begin
      failed++; $display("FAIL single.idle got busy=%b resp_val=%b exp busy=0 resp_val=0000", a_busy, a_resp_val);
    end
  endtask

  task automatic test_round_robin();
    int g; logic [3:0] rv;
    a_do_reset();
    a_lat = 1;
    for (int i = 0; i < 4; i++) a_req_msg[i*MW +: MW] = mk(3'd0, 32'(i + 1), 32'd10);
    a_req_val = 4'b1111;
    for (int op = 0; op < 8; op++) begin
      a_wait_issue(g);
      tests++;
      if (g !== op % 4) begin failed++; $display("FAIL rr.grant op=%0d got=%0d exp=%0d", op, g, op % 4); end
      @(negedge clk);
      a_wait_resp(rv);
      tests++;
      if (rv !== 4'(1 << (op % 4)) || a_resp_msg !== 32'(10 * (op % 4 + 1))) begin
        failed++;
        $display("FAIL rr.resp op=%0d got val=%b msg=%0d exp val=%b msg=%0d",
                 op, rv, a_resp_msg, 4'(1 << (op % 4)), 10 * (op % 4 + 1));
      end
      @(negedge clk);
    end
    a_wait_issue(g);
    a_req_val = '0;
    tests++;
    if (g !== 0) begin failed++; $display("FAIL rr.ptr_wrap got grant=%0d exp=0", g); end
    @(negedge clk); #1;
    tests++;
    if (a_busy !== 1'b0) begin failed++; $display("FAIL rr.withdraw got busy=%b exp=0", a_busy); end
  endtask

  task automatic test_back_pressure();
    int g; logic [3:0] rv; logic [MW-1:0] m3;
    a_do_reset();
    a_lat = 2;
    m3 = mk(3'd0, 32'd4, 32'd4);
    a_req_msg[1*MW +: MW] = mk(3'd0, 32'd3, 32'd5);
    a_req_msg[3*MW +: MW] = m3;
    a_req_val = 4'b0010;
    a_wait_issue(g);
    tests++;
    if (g !== 1) begin failed++; $display("FAIL bp.grant got=%0d exp=1", g); end
    @(negedge clk);
    a_req_val = 4'b1000; a_resp_rdy = 4'b1101;
    a_wait_resp(rv);
    tests++;
    if (rv !== 4'b0010 || a_resp_msg !== 32'd15) begin
      failed++; $display("FAIL bp.resp got val=%b msg=%0d exp val=0010 msg=15", rv, a_resp_msg);
    end
    for (int k = 0; k < 5; k++) begin
      if (k > 0) begin @(negedge clk); #1; end
      tests++;
      if (a_mul_out_rdy !== 1'b0 || a_resp_val !== 4'b0010 || a_busy !== 1'b1 || a_req_rdy !== 4'b0000) begin
        failed++;
        $display("FAIL bp.hold k=%0d got out_rdy=%b resp_val=%b busy=%b req_rdy=%b exp 0,0010,1,0000",
                 k, a_mul_out_rdy, a_resp_val, a_busy, a_req_rdy);
      end
    end
    @(negedge clk); a_resp_rdy = 4'b1111; #1;
    tests++;
    if (a_mul_out_rdy !== 1'b1 || a_req_rdy !== 4'b0000 || a_mul_in_val !== 1'b0) begin
      failed++; $display("FAIL bp.release got out_rdy=%b req_rdy=%b in_val=%b exp 1,0000,0",
                         a_mul_out_rdy, a_req_rdy, a_mul_in_val);
    end
    @(negedge clk); #1;
    tests++;
    if (a_busy !== 1'b0 || a_req_rdy !== 4'b1000 || a_mul_in_msg !== m3) begin
      failed++; $display("FAIL bp.next_issue got busy=%b req_rdy=%b msg=%h exp 0,1000,%h",
                         a_busy, a_req_rdy, a_mul_in_msg, m3);
    end
    @(negedge clk); a_req_val = '0;
    a_wait_resp(rv);
    tests++;
    if (rv !== 4'b1000 || a_resp_msg !== 32'd16) begin
      failed++; $display("FAIL bp.resp3 got val=%b msg=%0d exp val=1000 msg=16", rv, a_resp_msg);
    end
    @(negedge clk);
  endtask

  task automatic test_non_owner();
    int g; logic [3:0] rv;
    a_do_reset();
    a_lat = 1;
    a_req_msg[0 +: MW] = mk(3'd0, 32'd9, 32'd9);
    a_req_val = 4'b0001;
    a_wait_issue(g);
    tests++;
    if (g !== 0) begin failed++; $display("FAIL iso.grant got=%0d exp=0", g); end
    @(negedge clk);
    a_req_val = '0; a_resp_rdy = 4'b1110;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      tests++;
      if (a_resp_val !== 4'b0001 || a_mul_out_rdy !== 1'b0 || a_busy !== 1'b1) begin
        failed++; $display("FAIL iso.hold k=%0d got resp_val=%b out_rdy=%b busy=%b exp 0001,0,1",
                           k, a_resp_val, a_mul_out_rdy, a_busy);
      end
    end
    @(negedge clk); a_resp_rdy = 4'b1111; #1;
    tests++;
    if (a_mul_out_rdy !== 1'b1 || a_resp_msg !== 32'd81) begin
      failed++; $display("FAIL iso.release got out_rdy=%b msg=%0d exp 1,81", a_mul_out_rdy, a_resp_msg);
    end
    @(negedge clk); #1;
    tests++;
    if (a_busy !== 1'b0) begin failed++; $display("FAIL iso.idle got busy=%b exp=0", a_busy); end
  endtask

  task automatic test_reset_mid_op();
    int g; logic [3:0] rv;
    a_do_reset();
    a_lat = 10;
    a_req_msg[3*MW +: MW] = mk(3'd0, 32'd2, 32'd2);
    a_req_msg[1*MW +: MW] = mk(3'd0, 32'd6, 32'd7);
    a_req_msg[0 +: MW]    = mk(3'd0, 32'd1, 32'd1);
    a_req_msg[2*MW +: MW] = mk(3'd0, 32'd1, 32'd1);
    a_req_val = 4'b1000;
    a_wait_issue(g);
    tests++;
    if (g !== 3) begin failed++; $display("FAIL rst_mid.grant3 got=%0d exp=3", g); end
    @(negedge clk); a_req_val = '0;
    @(negedge clk); a_reset = 1'b1;
    @(negedge clk); #1;
    a_reset = 1'b0;
    @(negedge clk); #1;
    tests++;
    if (a_busy !== 1'b0 || a_owner !== 2'd0 || a_resp_val !== 4'b0000) begin
      failed++; $display("FAIL rst_mid.after got busy=%b owner=%0d resp_val=%b exp 0,0,0000",
                         a_busy, a_owner, a_resp_val);
    end
    a_lat = 2;
    a_req_val = 4'b0010;
    a_wait_issue(g);
    tests++;
    if (g !== 1) begin failed++; $display("FAIL rst_mid.grant1 got=%0d exp=1", g); end
    @(negedge clk); a_req_val = '0;
    a_wait_resp(rv);
    tests++;
    if (rv !== 4'b0010 || a_resp_msg !== 32'd42) begin
      failed++; $display("FAIL rst_mid.resp got val=%b msg=%0d exp val=0010 msg=42", rv, a_resp_msg);
    end
    @(negedge clk);
    a_req_val = 4'b0111;
    a_wait_issue(g);
    a_req_val = '0;
    tests++;
    if (g !== 2) begin failed++; $display("FAIL rst_mid.ptr got grant=%0d exp=2", g); end
    @(negedge clk);
  endtask

  task automatic test_idle_outval();
    a_do_reset();
    a_force_outval = 1'b1; #1;
    tests++;
    if (a_resp_val !== 4'b0000 || a_mul_out_rdy !== 1'b0 || a_busy !== 1'b0) begin
      failed++; $display("FAIL idle_outval got resp_val=%b out_rdy=%b busy=%b exp 0000,0,0",
                         a_resp_val, a_mul_out_rdy, a_busy);
    end
    @(negedge clk); a_force_outval = 1'b0;
  endtask

  task automatic test_wrap3();
    int g; logic [2:0] rv; int exp_g; logic [31:0] exp_m;
    b_do_reset();
    b_lat = 2;
    b_req_msg[1*MW +: MW] = mk(3'd0, 32'd3, 32'd3);
    b_req_msg[2*MW +: MW] = mk(3'd0, 32'hFFFF_FFFF, 32'd2);
    b_req_msg[0 +: MW]    = mk(3'd0, 32'h0001_0000, 32'h0001_0001);
    b_req_val = 3'b010;
    b_wait_issue(g);
    tests++;
    if (g !== 1) begin failed++; $display("FAIL wrap3.grant1 got=%0d exp=1", g); end
    @(negedge clk); b_req_val = 3'b101;
    b_wait_resp(rv);
    tests++;
    if (rv !== 3'b010 || b_resp_msg !== 32'd9) begin
      failed++; $display("FAIL wrap3.resp1 got val=%b msg=%0d exp val=010 msg=9", rv, b_resp_msg);
    end
    @(negedge clk);
    for (int op = 0; op < 4; op++) begin
      exp_g = (op % 2 == 0) ? 2 : 0;
      exp_m = (exp_g == 2) ? 32'hFFFF_FFFE : 32'h0001_0000;
      b_wait_issue(g);
      tests++;
      if (g !== exp_g) begin failed++; $display("FAIL wrap3.grant op=%0d got=%0d exp=%0d", op, g, exp_g); end
      @(negedge clk);
      b_wait_resp(rv);
      tests++;
      if (rv !== 3'(1 << exp_g) || b_resp_msg !== exp_m) begin
        failed++; $display("FAIL wrap3.resp op=%0d got val=%b msg=%h exp val=%b msg=%h",
                           op, rv, b_resp_msg, 3'(1 << exp_g), exp_m);
      end
      @(negedge clk);
    end
    b_req_val = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_back_pressure();
    test_non_owner();
    test_reset_mid_op();
    test_idle_outval();
    test_wrap3();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
